alu_op_sequencer: RTL and testbench

//  Upstream control stage of the 4-bit ALU. Accepts ALU commands (opcode + two

---
 rtl/alu_op_sequencer_pkg.sv | 39 +++
 rtl/alu_op_sequencer_if.sv | 39 +++
 rtl/alu_op_sequencer_cmd_fifo.sv | 85 ++++++++
 rtl/alu_op_sequencer.sv | 156 +++++++++++++++
 tb/tb_alu_op_sequencer.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// alu4_pkg
// Shared types for the 4-bit ALU control path:
//   ALU_WIDTH / ALU_OP_W : operand/result width and opcode (decoder select) width
//   alu_op_e             : the eight ALU operation codes
//   seq_state_e          : sequencer FSM states
//   alu_cmd_t            : one buffered command {opcode, a, b}
// -----------------------------------------------------------------------------
package alu4_pkg;

  localparam int ALU_WIDTH = 4;
  localparam int ALU_OP_W  = 3;

  // Every 3-bit code is a legal operation; the sequencer passes the code
  // through to the decoder unchanged and never interprets it.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } seq_state_e;

  typedef struct packed {
    alu_op_e              opcode;
    logic [ALU_WIDTH-1:0] a;
    logic [ALU_WIDTH-1:0] b;
  } alu_cmd_t;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer_if
// Command and response valid/ready channels of the ALU op sequencer.
//   cmd_valid/cmd_ready/cmd_opcode/cmd_a/cmd_b : command channel (host -> seq)
//   rsp_valid/rsp_ready/rsp_result/rsp_carry/rsp_opcode : response channel
// Modports:
//   master : the host side (issues commands, consumes responses)
//   slave  : the sequencer side
// -----------------------------------------------------------------------------
interface alu_op_sequencer_if
  import alu4_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int OP_W  = ALU_OP_W
);

  logic             cmd_valid;
  logic             cmd_ready;
  logic [OP_W-1:0]  cmd_opcode;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic [OP_W-1:0]  rsp_opcode;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_opcode
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, rsp_ready,
    output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_opcode
  );

endinterface

// File: rtl/alu_op_sequencer_cmd_fifo.sv
// -----------------------------------------------------------------------------
// alu_cmd_fifo
// DEPTH-entry synchronous FIFO of alu_cmd_t with a first-word-fall-through
// head, so the sequencer can latch the head on the same edge it pops it.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (empties the FIFO)
//   push        : write push_data (ignored while full)
//   push_data   : command to store
//   pop         : drop the head entry (ignored while empty)
//   head        : current head entry (valid when !empty)
//   full, empty : occupancy flags decoded from the pointers
// -----------------------------------------------------------------------------
module alu_cmd_fifo
  import alu4_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  alu_cmd_t push_data,
  input  logic     pop,
  output alu_cmd_t head,
  output logic     full,
  output logic     empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  // when the indices are equal.
  logic [AW:0]    wr_ptr_q, wr_ptr_d;
  logic [AW:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]  wr_idx;
  logic [AW-1:0]  rd_idx;
  logic           push_ok;
  logic           pop_ok;
  logic [DEPTH-1:0] wr_en;
  alu_cmd_t       mem_q [DEPTH];

  assign wr_idx = wr_ptr_q[AW-1:0];
  assign rd_idx = rd_ptr_q[AW-1:0];

  assign full  = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  // A pop never frees a slot for a push in the same cycle: push is gated by
  // the registered full flag alone.
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push_ok && (wr_idx == AW'(gi));
    end
  endgenerate

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (wr_en[i]) mem_q[i] <= push_data;
    end
  end

  assign head = mem_q[rd_idx];

endmodule

// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
// Upstream control stage of the 4-bit ALU. Buffers commands in a small FIFO,
// drives the operation decoder and ALU operand buses for ALU_LAT cycles,
// captures the ALU result and returns it in order over the response channel.
// Ports:
//   clk, rst               : clock, synchronous active-high reset
//   bus (slave)            : command and response valid/ready channels
//   dec_enable, dec_select : operation-decoder enable and select
//   alu_a, alu_b           : operand buses to the ALU
//   alu_result, alu_carry  : combinational ALU outputs, captured at end of ISSUE
//   busy                   : FSM not IDLE, or commands still queued
//   op_count               : completed responses, wraps at 256
// -----------------------------------------------------------------------------
module alu_op_sequencer
  import alu4_pkg::*;
#(
  parameter int WIDTH   = ALU_WIDTH,
  parameter int OP_W    = ALU_OP_W,
  parameter int DEPTH   = 2,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  alu_op_sequencer_if.slave bus,
  output logic             dec_enable,
  output logic [OP_W-1:0]  dec_select,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  output logic             busy,
  output logic [7:0]       op_count
);

  // Counter holds the number of ISSUE cycles remaining after the current one.
  localparam int            LAT_W    = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(ALU_LAT - 1);

  seq_state_e       state_q, state_d;
  logic [LAT_W-1:0] lat_cnt_q, lat_cnt_d;
  alu_cmd_t         op_q, op_d;
  logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
  logic             rsp_carry_q, rsp_carry_d;
  logic [OP_W-1:0]  rsp_opcode_q, rsp_opcode_d;
  logic [7:0]       op_count_q, op_count_d;

  alu_cmd_t push_cmd;
  alu_cmd_t fifo_head;
  logic     fifo_full;
  logic     fifo_empty;
  logic     push;
  logic     pop;

  assign push_cmd = '{opcode: alu_op_e'(bus.cmd_opcode), a: bus.cmd_a, b: bus.cmd_b};
  assign push     = bus.cmd_valid && bus.cmd_ready;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_cmd),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    op_d         = op_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_opcode_d = rsp_opcode_q;
    op_count_d   = op_count_q;
    pop          = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          op_d      = fifo_head;
          lat_cnt_d = LAT_INIT;
          state_d   = ISSUE;
        end
      end

      ISSUE: begin
        if (lat_cnt_q == '0) begin
          rsp_result_d = alu_result;
          rsp_carry_d  = alu_carry;
          rsp_opcode_d = op_q.opcode;
          state_d      = RESPOND;
        end else begin
          lat_cnt_d = lat_cnt_q - LAT_W'(1);
        end
      end

      RESPOND: begin
        if (bus.rsp_ready) begin
          op_count_d = op_count_q + 8'd1;
          // Chain straight into the next command to sustain one op per
          // ALU_LAT+1 cycles.
          if (!fifo_empty) begin
            pop       = 1'b1;
            op_d      = fifo_head;
            lat_cnt_d = LAT_INIT;
            state_d   = ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      lat_cnt_q    <= '0;
      op_q         <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_opcode_q <= '0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      op_q         <= op_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_opcode_q <= rsp_opcode_d;
      op_count_q   <= op_count_d;
    end
  end

  // Operand buses come straight from the op register, so they hold their
  // last values outside ISSUE.
  assign dec_enable = (state_q == ISSUE);
  assign dec_select = op_q.opcode;
  assign alu_a      = op_q.a;
  assign alu_b      = op_q.b;

  assign bus.cmd_ready  = !fifo_full;
  assign bus.rsp_valid  = (state_q == RESPOND);
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_carry  = rsp_carry_q;
  assign bus.rsp_opcode = rsp_opcode_q;

  assign busy     = (state_q != IDLE) || !fifo_empty;
  assign op_count = op_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
// Directed bench for alu_op_sequencer. u_dut1 runs with ALU_LAT=1, u_dut3 with
// ALU_LAT=3. A small ALU model sits behind each decoder/operand bus.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ALU_LAT = 1 instance
  logic       rst1;
  logic       dec_enable1;
  logic [2:0] dec_select1;
  logic [3:0] alu_a1, alu_b1, alu_result1;
  logic       alu_carry1, busy1;
  logic [7:0] op_count1;
  alu_op_sequencer_if #(.WIDTH(4), .OP_W(3)) bus1 ();

  // ALU_LAT = 3 instance
  logic       rst3;
  logic       dec_enable3;
  logic [2:0] dec_select3;
  logic [3:0] alu_a3, alu_b3, alu_result3;
  logic       alu_carry3, busy3;
  logic [7:0] op_count3;
  alu_op_sequencer_if #(.WIDTH(4), .OP_W(3)) bus3 ();

  alu_op_sequencer #(.WIDTH(4), .OP_W(3), .DEPTH(2), .ALU_LAT(1)) u_dut1 (
    .clk(clk), .rst(rst1), .bus(bus1),
    .dec_enable(dec_enable1), .dec_select(dec_select1),
    .alu_a(alu_a1), .alu_b(alu_b1),
    .alu_result(alu_result1), .alu_carry(alu_carry1),
    .busy(busy1), .op_count(op_count1)
  );

  alu_op_sequencer #(.WIDTH(4), .OP_W(3), .DEPTH(2), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst(rst3), .bus(bus3),
    .dec_enable(dec_enable3), .dec_select(dec_select3),
    .alu_a(alu_a3), .alu_b(alu_b3),
    .alu_result(alu_result3), .alu_carry(alu_carry3),
    .busy(busy3), .op_count(op_count3)
  );

  // Returns {carry, result}. SUB carry is the borrow.
  function automatic logic [4:0] alu_f(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    case (op)
      3'd0:    return {1'b0, a} + {1'b0, b};
      3'd1:    return {1'b0, a} - {1'b0, b};
      3'd2:    return {1'b0, a & b};
      3'd3:    return {1'b0, a | b};
      3'd4:    return {1'b0, a ^ b};
      3'd5:    return {1'b0, ~a};
      3'd6:    return {a, 1'b0};
      default: return {a[0], 1'b0, a[3:1]};
    endcase
  endfunction

  // The decoder output is zero while disabled, so the ALU then yields zero.
  always_comb begin
    {alu_carry1, alu_result1} = 5'd0;
    if (dec_enable1) {alu_carry1, alu_result1} = alu_f(dec_select1, alu_a1, alu_b1);
  end

  always_comb begin
    {alu_carry3, alu_result3} = 5'd0;
    if (dec_enable3) {alu_carry3, alu_result3} = alu_f(dec_select3, alu_a3, alu_b3);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offer one command to u_dut1 and hold it until accepted (bounded).
  task automatic push1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
    int   n;
    logic acc;
    n = 0;
    bus1.cmd_valid  = 1'b1;
    bus1.cmd_opcode = op;
    bus1.cmd_a      = a;
    bus1.cmd_b      = b;
    do begin
      acc = bus1.cmd_ready;
      tick();
      n++;
    end while (!acc && n < 200);
    bus1.cmd_valid = 1'b0;
    chk("push_accept", 32'(acc), 1);
    $display("push op=%0d a=%h b=%h", op, a, b);
  endtask

  // Wait (bounded) for a u_dut1 response, check it, then take it.
  task automatic collect1(input string tag, input logic [2:0] op, input logic [3:0] res, input logic c);
    int n;
    n = 0;
    bus1.rsp_ready = 1'b1;
    while (!bus1.rsp_valid && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_valid"}, 32'(bus1.rsp_valid), 1);
    chk({tag, "_data"}, 32'({bus1.rsp_opcode, bus1.rsp_carry, bus1.rsp_result}), 32'({op, c, res}));
    $display("rsp %s op=%0d res=%h carry=%b", tag, bus1.rsp_opcode, bus1.rsp_result, bus1.rsp_carry);
    tick();
  endtask

  localparam int N_WRAP = 251;
  logic [7:0] exp_q[$];

  initial begin
    rst1 = 1'b1;
    rst3 = 1'b1;
    bus1.cmd_valid = 1'b0; bus1.cmd_opcode = '0; bus1.cmd_a = '0; bus1.cmd_b = '0;
    bus1.rsp_ready = 1'b0;
    bus3.cmd_valid = 1'b0; bus3.cmd_opcode = '0; bus3.cmd_a = '0; bus3.cmd_b = '0;
    bus3.rsp_ready = 1'b0;

    // ---- reset ----
    tick();
    tick();
    rst1 = 1'b0;
    rst3 = 1'b0;
    chk("rst_cmd_ready", 32'(bus1.cmd_ready), 1);
    chk("rst_rsp_valid", 32'(bus1.rsp_valid), 0);
    chk("rst_dec_enable", 32'(dec_enable1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_op_count", 32'(op_count1), 0);
    chk("rst_outputs3", 32'({bus3.cmd_ready, bus3.rsp_valid, dec_enable3, busy3, op_count3}), 32'({1'b1, 11'd0}));

    // ---- single op: NOT 3 -> C ----
    push1(3'd5, 4'h3, 4'h9);
    chk("single_c0_busy", 32'({busy1, dec_enable1}), 32'(2'b10));
    tick();
    chk("single_c1_enable", 32'(dec_enable1), 1);
    chk("single_c1_buses", 32'({dec_select1, alu_a1, alu_b1}), 32'({3'd5, 4'h3, 4'h9}));
    chk("single_c1_no_rsp", 32'(bus1.rsp_valid), 0);
    tick();
    chk("single_c2_rsp", 32'({bus1.rsp_valid, dec_enable1, bus1.rsp_opcode, bus1.rsp_carry, bus1.rsp_result}),
        32'({1'b1, 1'b0, 3'd5, 1'b0, 4'hC}));
    bus1.rsp_ready = 1'b1;
    tick();
    bus1.rsp_ready = 1'b0;
    chk("single_done", 32'({bus1.rsp_valid, busy1, op_count1}), 32'({2'b00, 8'd1}));
    chk("single_hold_buses", 32'({dec_select1, alu_a1, alu_b1}), 32'({3'd5, 4'h3, 4'h9}));

    // ---- back-pressure: three pushes with rsp_ready low ----
    push1(3'd0, 4'h7, 4'h9);   // ADD -> 0, carry 1
    push1(3'd1, 4'h2, 4'h5);   // SUB -> D, borrow 1
    push1(3'd4, 4'hA, 4'h6);   // XOR -> C
    chk("bp_full", 32'({bus1.cmd_ready, busy1, dec_enable1}), 32'(3'b010));
    for (int i = 0; i < 10; i++) begin
      chk("bp_hold", 32'({bus1.rsp_valid, bus1.rsp_carry, bus1.rsp_opcode, bus1.rsp_result, bus1.cmd_ready}),
          32'({1'b1, 1'b1, 3'd0, 4'h0, 1'b0}));
      tick();
    end

    // ---- full + pop: push offered while full in the pop cycle ----
    bus1.cmd_valid  = 1'b1;
    bus1.cmd_opcode = 3'd2;    // AND C,A -> 8
    bus1.cmd_a      = 4'hC;
    bus1.cmd_b      = 4'hA;
    bus1.rsp_ready  = 1'b1;
    chk("fp_ready_before", 32'(bus1.cmd_ready), 0);
    tick();
    $display("rsp bp0 op=0 res=0 carry=1 taken");
    chk("fp_count", 32'(op_count1), 2);
    chk("fp_ready_after", 32'(bus1.cmd_ready), 1);
    chk("fp_issue", 32'({dec_enable1, dec_select1, alu_a1}), 32'({1'b1, 3'd1, 4'h2}));
    tick();
    bus1.cmd_valid = 1'b0;
    $display("push op=2 a=c b=a");
    collect1("bp1", 3'd1, 4'hD, 1'b1);
    collect1("bp2", 3'd4, 4'hC, 1'b0);
    collect1("fp3", 3'd2, 4'h8, 1'b0);
    tick();
    tick();
    chk("fp_drained", 32'({bus1.rsp_valid, busy1, op_count1}), 32'({2'b00, 8'd5}));
    bus1.rsp_ready = 1'b0;

    // ---- ALU_LAT=3: reset on the 2nd ISSUE cycle ----
    bus3.cmd_valid = 1'b1; bus3.cmd_opcode = 3'd0; bus3.cmd_a = 4'hF; bus3.cmd_b = 4'h1;
    tick();
    bus3.cmd_valid = 1'b0;
    tick();
    chk("l3_issue1", 32'(dec_enable3), 1);
    tick();
    chk("l3_issue2", 32'({dec_enable3, bus3.rsp_valid}), 32'(2'b10));
    rst3 = 1'b1;
    tick();
    rst3 = 1'b0;
    chk("l3_rst_outputs", 32'({bus3.cmd_ready, bus3.rsp_valid, dec_enable3, busy3, op_count3}), 32'({1'b1, 11'd0}));
    chk("l3_rst_buses", 32'({dec_select3, alu_a3, alu_b3, bus3.rsp_result, bus3.rsp_carry, bus3.rsp_opcode}), 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
        if (bus3.rsp_valid || dec_enable3) seen++;
        tick();
      end
      chk("l3_no_rsp_after_rst", 32'(seen), 0);
    end

    // ---- ALU_LAT=3: full latency, SHL 9 -> 2 carry 1 ----
    bus3.cmd_valid = 1'b1; bus3.cmd_opcode = 3'd6; bus3.cmd_a = 4'h9; bus3.cmd_b = 4'h0;
    tick();
    bus3.cmd_valid = 1'b0;
    $display("push3 op=6 a=9 b=0");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l3_issue_len", 32'({dec_enable3, bus3.rsp_valid}), 32'(2'b10));
    end
    tick();
    chk("l3_rsp", 32'({bus3.rsp_valid, dec_enable3, bus3.rsp_opcode, bus3.rsp_carry, bus3.rsp_result}),
        32'({1'b1, 1'b0, 3'd6, 1'b1, 4'h2}));
    $display("rsp3 op=%0d res=%h carry=%b", bus3.rsp_opcode, bus3.rsp_result, bus3.rsp_carry);
    bus3.rsp_ready = 1'b1;
    tick();
    bus3.rsp_ready = 1'b0;
    chk("l3_count", 32'({bus3.rsp_valid, op_count3}), 32'({1'b0, 8'd1}));

    // ---- wrap: finish 256 ops on u_dut1 with a scoreboard ----
    fork
      begin
        logic [2:0] op;
        logic [3:0] a, b;
        for (int i = 0; i < N_WRAP; i++) begin
          op = 3'($urandom_range(0, 7));
          a  = 4'($urandom_range(0, 15));
          b  = 4'($urandom_range(0, 15));
          exp_q.push_back({op, alu_f(op, a, b)});
          push1(op, a, b);
        end
      end
      begin
        int   got;
        int   cyc;
        logic rdy;
        logic [7:0] e;
        got = 0;
        cyc = 0;
        while (got < N_WRAP && cyc < 8000) begin
          rdy = ($urandom_range(0, 3) != 0);
          bus1.rsp_ready = rdy;
          if (bus1.rsp_valid && rdy) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hFF;
            chk("wrap_rsp", 32'({bus1.rsp_opcode, bus1.rsp_carry, bus1.rsp_result}), 32'(e));
            $display("rsp wrap#%0d op=%0d res=%h carry=%b", got, bus1.rsp_opcode, bus1.rsp_result, bus1.rsp_carry);
            got++;
          end
          tick();
          cyc++;
        end
        bus1.rsp_ready = 1'b0;
        chk("wrap_rsp_count", 32'(got), N_WRAP);
      end
    join
    tick();
    tick();
    chk("wrap_op_count", 32'({op_count1, busy1, bus1.rsp_valid}), 32'({8'd0, 2'b00}));
    chk("wrap_queue_empty", 32'(exp_q.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
